// File: rtl/memory_arbiter_if.sv
// Core/RAM bus bundle shared by the memory arbiter and whatever drives it.
// The arbiter takes the slave modport; the core-plus-RAM side takes master.
interface memory_arbiter_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  fetch_req;
  logic [31:0]           fetch_addr;
  logic                  fetch_ready;
  logic                  fetch_valid;
  logic [31:0]           fetch_data;

  logic                  data_req;
  logic [31:0]           data_addr;
  logic [2:0]            data_write_sections;
  logic [31:0]           data_wdata;
  logic                  data_ready;
  logic                  data_valid;
  logic [31:0]           data_rdata;
  logic                  data_fault;

  logic                  ram_en;
  logic [3:0]            ram_we;
  logic [ADDR_WIDTH-3:0] ram_addr;
  logic [31:0]           ram_wdata;
  logic [31:0]           ram_rdata;

  modport slave (
    input  fetch_req, fetch_addr,
    output fetch_ready, fetch_valid, fetch_data,
    input  data_req, data_addr, data_write_sections, data_wdata,
    output data_ready, data_valid, data_rdata, data_fault,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output fetch_req, fetch_addr,
    input  fetch_ready, fetch_valid, fetch_data,
    output data_req, data_addr, data_write_sections, data_wdata,
    input  data_ready, data_valid, data_rdata, data_fault,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/memory_arbiter.sv
// Two-cycle arbiter sharing one 32-bit single-port RAM between fetch and data ports.
// Optional access checking is enabled by defining MEM_ARB_FAULT_EN.
module memory_arbiter #(
  parameter int ADDR_WIDTH   = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk48,
  input  logic              reset,
  memory_arbiter_if.slave   bus
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT_F = 3'd1,
    GRANT_D = 3'd2,
    RESP_F  = 3'd3,
    RESP_D  = 3'd4
  } state_e;

  state_e                state_q;
  logic [CW-1:0]         starve_q;
  logic                  fetch_ready_q;
  logic                  data_ready_q;
  logic                  fetch_valid_q;
  logic                  data_valid_q;
  logic                  bad_q;
  logic                  ram_en_q;
  logic [3:0]            ram_we_q;
  logic [ADDR_WIDTH-3:0] ram_addr_q;
  logic [31:0]           ram_wdata_q;

  logic                  can_grant_s;
  logic                  pick_f_s;
  logic                  grant_f_s;
  logic                  grant_d_s;
  logic                  f_bad_s;
  logic                  d_bad_s;
  logic [3:0]            d_we_s;
  logic [31:0]           d_wdata_s;

  // Lanes pushed past byte 3 fall off the top rather than wrapping.
  function automatic logic [3:0] lane_we_f(input logic [2:0] sec, input logic [1:0] off);
    logic [3:0] base;
    base = {sec[2], sec[2], sec[1], sec[0]};
    return base << off;
  endfunction

`ifdef MEM_ARB_FAULT_EN
  function automatic logic data_bad_f(input logic [2:0] sec, input logic [31:0] addr);
    logic illegal;
    logic misaligned;
    logic out_of_range;
    illegal      = (sec == 3'b010) || (sec == 3'b100) || (sec == 3'b101) || (sec == 3'b110);
    misaligned   = ((sec == 3'b011) && addr[0]) || ((sec == 3'b111) && (addr[1:0] != 2'b00));
    out_of_range = |addr[31:ADDR_WIDTH];
    return illegal || misaligned || out_of_range;
  endfunction

  assign d_bad_s = data_bad_f(bus.data_write_sections, bus.data_addr);
  assign f_bad_s = (bus.fetch_addr[1:0] != 2'b00) || (|bus.fetch_addr[31:ADDR_WIDTH]);
`else
  assign d_bad_s = 1'b0;
  assign f_bad_s = 1'b0;
`endif

  assign can_grant_s = (state_q == IDLE) || (state_q == RESP_F) || (state_q == RESP_D);
  assign pick_f_s    = bus.fetch_req && (!bus.data_req || (starve_q == CW'(STARVE_LIMIT)));
  assign grant_f_s   = can_grant_s && pick_f_s;
  assign grant_d_s   = can_grant_s && bus.data_req && !pick_f_s;
  assign d_we_s      = lane_we_f(bus.data_write_sections, bus.data_addr[1:0]);
  assign d_wdata_s   = bus.data_wdata << {bus.data_addr[1:0], 3'b000};

  // Arbitration state machine with registered RAM strobes and handshakes.
  always_ff @(posedge clk48 or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      starve_q      <= '0;
      fetch_ready_q <= 1'b0;
      data_ready_q  <= 1'b0;
      fetch_valid_q <= 1'b0;
      data_valid_q  <= 1'b0;
      bad_q         <= 1'b0;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 4'b0000;
      ram_addr_q    <= '0;
      ram_wdata_q   <= 32'h0000_0000;
    end else begin
      fetch_ready_q <= 1'b0;
      data_ready_q  <= 1'b0;
      fetch_valid_q <= 1'b0;
      data_valid_q  <= 1'b0;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 4'b0000;
      ram_addr_q    <= '0;
      ram_wdata_q   <= 32'h0000_0000;

      case (state_q)
        GRANT_F: begin
          state_q       <= RESP_F;
          fetch_valid_q <= 1'b1;
        end
        GRANT_D: begin
          state_q      <= RESP_D;
          data_valid_q <= 1'b1;
        end
        IDLE, RESP_F, RESP_D: begin
          if (grant_f_s) begin
            state_q       <= GRANT_F;
            fetch_ready_q <= 1'b1;
            bad_q         <= f_bad_s;
            ram_en_q      <= !f_bad_s;
            ram_addr_q    <= f_bad_s ? '0 : bus.fetch_addr[ADDR_WIDTH-1:2];
          end else if (grant_d_s) begin
            state_q      <= GRANT_D;
            data_ready_q <= 1'b1;
            bad_q        <= d_bad_s;
            ram_en_q     <= !d_bad_s;
            ram_addr_q   <= d_bad_s ? '0 : bus.data_addr[ADDR_WIDTH-1:2];
            ram_we_q     <= d_bad_s ? 4'b0000 : d_we_s;
            ram_wdata_q  <= d_bad_s ? 32'h0000_0000 : d_wdata_s;
          end else begin
            state_q <= IDLE;
            bad_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          bad_q   <= 1'b0;
        end
      endcase

      // Count only data wins that actually made fetch wait.
      if (!bus.fetch_req) begin
        starve_q <= '0;
      end else if (grant_f_s) begin
        starve_q <= '0;
      end else if (grant_d_s) begin
        starve_q <= starve_q + CW'(1);
      end else begin
        starve_q <= starve_q;
      end
    end
  end

  assign bus.fetch_ready = fetch_ready_q;
  assign bus.data_ready  = data_ready_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.ram_en      = ram_en_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_wdata   = ram_wdata_q;
  assign bus.fetch_data  = (fetch_valid_q && !bad_q) ? bus.ram_rdata : 32'h0000_0000;
  assign bus.data_rdata  = (data_valid_q && !bad_q) ? bus.ram_rdata : 32'h0000_0000;

`ifdef MEM_ARB_FAULT_EN
  assign bus.data_fault = data_valid_q && bad_q;
`else
  assign bus.data_fault = 1'b0;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: drivers queue expected grants/responses,
// a negedge monitor pops and compares whenever the DUT shows ready or valid.
module tb_memory_arbiter;

  localparam int AW = 12;

  logic clk48    = 1'b0;
  logic reset    = 1'b1;
  logic mem_init = 1'b1;

  always #5 clk48 = ~clk48;

  memory_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  memory_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(4)) dut (
    .clk48 (clk48),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic          is_f;
    logic          en;
    logic [AW-3:0] addr;
    logic [3:0]    we;
    logic [31:0]   wdata;
  } grant_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] mask;
    logic        fault;
  } resp_t;

  grant_t gq[$];
  resp_t  fq[$];
  resp_t  dq[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int last_grant_cyc = 0;
  logic chk_gap  = 1'b0;
  logic have_last = 1'b0;

  logic [31:0] mem [0:1023];

  // Synchronous RAM model: one-cycle read latency, byte-lane writes.
  always @(posedge clk48) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= {16'hCAFE, 16'(i)};
    end else if (bus.ram_en) begin
      bus.ram_rdata <= mem[bus.ram_addr];
      for (int b = 0; b < 4; b++)
        if (bus.ram_we[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
    end
  end

  always @(posedge clk48) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  grant_t g_m;
  resp_t  r_m;

  // Monitor: compare every grant and response against the queued expectations.
  always @(negedge clk48) begin
    if (!reset) begin
      if (bus.fetch_ready || bus.data_ready) begin
        if (gq.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_grant: fetch_ready=%0b data_ready=%0b with nothing queued", bus.fetch_ready, bus.data_ready);
        end else begin
          g_m = gq.pop_front();
          chk("grant_fetch_ready", bus.fetch_ready, g_m.is_f);
          chk("grant_data_ready", bus.data_ready, !g_m.is_f);
          chk("ram_en", bus.ram_en, g_m.en);
          chk("ram_addr", bus.ram_addr, g_m.addr);
          chk("ram_we", bus.ram_we, g_m.we);
          chk("ram_wdata", bus.ram_wdata, g_m.wdata);
        end
        if (chk_gap && have_last) chk("grant_spacing", cyc - last_grant_cyc, 2);
        have_last = 1'b1;
        last_grant_cyc = cyc;
      end else if (bus.ram_en) begin
        chk("ram_en_without_ready", bus.ram_en, 1'b0);
      end

      if (bus.fetch_valid) begin
        if (fq.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_fetch_valid: fetch_data=0x%08h", bus.fetch_data);
        end else begin
          r_m = fq.pop_front();
          chk("fetch_data", bus.fetch_data & r_m.mask, r_m.data & r_m.mask);
        end
      end

      if (bus.data_valid) begin
        if (dq.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_data_valid: data_rdata=0x%08h", bus.data_rdata);
        end else begin
          r_m = dq.pop_front();
          chk("data_rdata", bus.data_rdata & r_m.mask, r_m.data & r_m.mask);
          chk("data_fault", bus.data_fault, r_m.fault);
        end
      end
    end
  end

  task automatic wait_ready(input logic want_f, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk48);
      if (want_f ? bus.fetch_ready : bus.data_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_chk++; n_err++;
      $display("FAIL ready_timeout: no %s ready within 20 cycles", want_f ? "fetch" : "data");
    end
  endtask

  task automatic do_fetch(input logic [31:0] addr, input logic en, input logic [AW-3:0] eaddr,
                          input logic [31:0] edata);
    logic ok;
    gq.push_back('{is_f: 1'b1, en: en, addr: eaddr, we: 4'b0000, wdata: 32'h0});
    fq.push_back('{data: edata, mask: 32'hFFFF_FFFF, fault: 1'b0});
    @(posedge clk48); #1;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = addr;
    wait_ready(1'b1, ok);
    bus.fetch_req = 1'b0;
    repeat (2) @(posedge clk48);
  endtask

  task automatic do_data(input logic [31:0] addr, input logic [2:0] sec, input logic [31:0] wdata,
                         input logic en, input logic [AW-3:0] eaddr, input logic [3:0] ewe,
                         input logic [31:0] ewdata, input logic [31:0] erdata,
                         input logic [31:0] emask, input logic efault);
    logic ok;
    gq.push_back('{is_f: 1'b0, en: en, addr: eaddr, we: ewe, wdata: ewdata});
    dq.push_back('{data: erdata, mask: emask, fault: efault});
    @(posedge clk48); #1;
    bus.data_req            = 1'b1;
    bus.data_addr           = addr;
    bus.data_write_sections = sec;
    bus.data_wdata          = wdata;
    wait_ready(1'b0, ok);
    bus.data_req = 1'b0;
    repeat (2) @(posedge clk48);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic ok;
    int   n;
    bus.fetch_req = 1'b0; bus.fetch_addr = 32'h0;
    bus.data_req = 1'b0; bus.data_addr = 32'h0;
    bus.data_write_sections = 3'b000; bus.data_wdata = 32'h0;
    repeat (3) @(posedge clk48);
    #1;
    chk("rst_fetch_ready", bus.fetch_ready, 1'b0);
    chk("rst_data_ready", bus.data_ready, 1'b0);
    chk("rst_fetch_valid", bus.fetch_valid, 1'b0);
    chk("rst_data_valid", bus.data_valid, 1'b0);
    chk("rst_ram_en", bus.ram_en, 1'b0);
    chk("rst_ram_we", bus.ram_we, 4'b0000);
    chk("rst_ram_addr", bus.ram_addr, 10'h000);
    chk("rst_ram_wdata", bus.ram_wdata, 32'h0);
    chk("rst_data_fault", bus.data_fault, 1'b0);
    @(negedge clk48);
    mem_init = 1'b0;
    reset    = 1'b0;

    // Basic fetch of word 4.
    do_fetch(32'h0000_0010, 1'b1, 10'h004, 32'hCAFE_0004);
    // Byte write to lane 1 of word 8.
    do_data(32'h21, 3'b001, 32'h0000_00AB, 1'b1, 10'h008, 4'b0010, 32'h0000_AB00, 32'h0, 32'h0, 1'b0);
    // Half write to upper lanes, then read back the merged word.
    do_data(32'h22, 3'b011, 32'h0000_1234, 1'b1, 10'h008, 4'b1100, 32'h1234_0000, 32'h0, 32'h0, 1'b0);
    do_data(32'h20, 3'b000, 32'h0, 1'b1, 10'h008, 4'b0000, 32'h0, 32'h1234_AB08, 32'hFFFF_FFFF, 1'b0);

    // Starvation: both held high, expect D,D,D,D,F twice, 2 cycles apart.
    for (int k = 0; k < 10; k++) begin
      if ((k % 5) == 4) begin
        gq.push_back('{is_f: 1'b1, en: 1'b1, addr: 10'h010, we: 4'b0000, wdata: 32'h0});
        fq.push_back('{data: 32'hCAFE_0010, mask: 32'hFFFF_FFFF, fault: 1'b0});
      end else begin
        gq.push_back('{is_f: 1'b0, en: 1'b1, addr: 10'h011, we: 4'b0000, wdata: 32'h0});
        dq.push_back('{data: 32'hCAFE_0011, mask: 32'hFFFF_FFFF, fault: 1'b0});
      end
    end
    @(posedge clk48); #1;
    chk_gap = 1'b1; have_last = 1'b0;
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h40;
    bus.data_req = 1'b1; bus.data_addr = 32'h44;
    bus.data_write_sections = 3'b000; bus.data_wdata = 32'h0;
    n = 0;
    for (int i = 0; i < 60 && n < 10; i++) begin
      @(negedge clk48);
      if (bus.fetch_ready || bus.data_ready) n++;
    end
    bus.fetch_req = 1'b0; bus.data_req = 1'b0;
    chk("starve_grant_count", n, 10);
    repeat (3) @(posedge clk48);
    chk_gap = 1'b0;

`ifdef MEM_ARB_FAULT_EN
    do_fetch(32'h0000_1010, 1'b0, 10'h000, 32'h0);
    do_data(32'h23, 3'b011, 32'h0000_5566, 1'b0, 10'h000, 4'b0000, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b1);
    do_data(32'h01, 3'b010, 32'h0000_0077, 1'b0, 10'h000, 4'b0000, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b1);
    do_data(32'h03, 3'b111, 32'h1122_3344, 1'b0, 10'h000, 4'b0000, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b1);
`else
    // High address bits ignored; shifted lanes truncate; illegal codes use their raw mask.
    do_fetch(32'h0000_1010, 1'b1, 10'h004, 32'hCAFE_0004);
    do_data(32'h23, 3'b011, 32'h0000_5566, 1'b1, 10'h008, 4'b1000, 32'h6600_0000, 32'h0, 32'h0, 1'b0);
    do_data(32'h01, 3'b010, 32'h0000_0077, 1'b1, 10'h000, 4'b0100, 32'h0000_7700, 32'h0, 32'h0, 1'b0);
    do_data(32'h03, 3'b111, 32'h1122_3344, 1'b1, 10'h000, 4'b1000, 32'h4400_0000, 32'h0, 32'h0, 1'b0);
`endif

    // Reset during GRANT_D abandons the access.
    gq.push_back('{is_f: 1'b0, en: 1'b1, addr: 10'h00C, we: 4'b0000, wdata: 32'h0});
    @(posedge clk48); #1;
    bus.data_req = 1'b1; bus.data_addr = 32'h30;
    bus.data_write_sections = 3'b000; bus.data_wdata = 32'h0;
    wait_ready(1'b0, ok);
    #2 reset = 1'b1;
    #1;
    chk("midrst_ram_en", bus.ram_en, 1'b0);
    chk("midrst_data_ready", bus.data_ready, 1'b0);
    bus.data_req = 1'b0;
    @(posedge clk48); #1;
    chk("midrst_data_valid", bus.data_valid, 1'b0);
    chk("midrst_ram_en_next", bus.ram_en, 1'b0);
    @(negedge clk48);
    reset = 1'b0;
    do_fetch(32'h0000_0010, 1'b1, 10'h004, 32'hCAFE_0004);

    repeat (4) @(posedge clk48);
    chk("grant_queue_left", gq.size(), 0);
    chk("fetch_queue_left", fq.size(), 0);
    chk("data_queue_left", dq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
